smmha_tcdm_responder: RTL and testbench
=======================================

SMMHA_TCDM_RESPONDER -- requirements
Module: smmha_tcdm_responder

Interface
REQ-001 Parameters: MEM_WORDS, default 1024, number of 32-bit words held by the array.
REQ-002 Parameters: LATENCY, default 1, range 1..4, cycles from grant to read response.
REQ-003 Parameters: STALL_PERIOD, default 0, grant-denial period; 0 disables stalling.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 Port clk_i, input, 1, clock; all state SHALL update on its rising edge.
REQ-006 Port rst_i, input, 1, synchronous active-high reset.
REQ-007 Port clear_i, input, 1, synchronous local clear.
REQ-008 Port tcdm_req_i, input, 1, request valid.
REQ-009 Port tcdm_gnt_o, output, 1, request accepted this cycle.
REQ-010 Port tcdm_add_i, input, 32, byte address.
REQ-011 Port tcdm_wen_i, input, 1, 1 = read, 0 = write.
REQ-012 Port tcdm_be_i, input, 4, write byte enables.
REQ-013 Port tcdm_data_i, input, 32, write data.
REQ-014 Port tcdm_r_data_o, output, 32, read data.
REQ-015 Port tcdm_r_valid_o, output, 1, read data valid.
REQ-016 Port err_o, output, 1, sticky out-of-range access flag.
REQ-017 Port rd_count_o, output, 16, count of granted reads, saturating.
REQ-018 Port wr_count_o, output, 16, count of granted writes, saturating.

Function
REQ-019 Word index SHALL be tcdm_add_i[31:2]; tcdm_add_i[1:0] SHALL be ignored.
REQ-020 tcdm_gnt_o SHALL be combinational: tcdm_req_i AND NOT stall, where stall = (STALL_PERIOD != 0) AND (stall_cnt == STALL_PERIOD-1).
REQ-021 stall_cnt SHALL increment, wrapping at STALL_PERIOD-1 to 0, only in cycles with tcdm_req_i=1; it SHALL hold otherwise.
REQ-022 A request is granted in a cycle where tcdm_req_i=1 and tcdm_gnt_o=1; an ungranted request SHALL cause no state change other than stall_cnt.
REQ-023 Granted write: at that clock edge, each byte i with tcdm_be_i[i]=1 SHALL take tcdm_data_i[8i+7:8i]; other bytes SHALL be unchanged; no r_valid SHALL be produced.
REQ-024 Granted read: the word SHALL be sampled at the grant edge, then carried through a LATENCY-deep valid/data pipeline.
REQ-025 tcdm_r_valid_o SHALL be 1 exactly LATENCY cycles after the grant cycle, for one cycle per granted read, with no back-pressure.
REQ-026 Back-to-back granted reads SHALL produce back-to-back responses in order; throughput SHALL be 1 per cycle.
REQ-027 A read granted in the cycle after a write to the same word SHALL return the newly written data.
REQ-028 tcdm_r_data_o SHALL be 0 in any cycle where tcdm_r_valid_o=0.
REQ-029 Out-of-range access: word index >= MEM_WORDS SHALL still be granted per REQ-020.
REQ-030 An out-of-range write SHALL be dropped.
REQ-031 An out-of-range read SHALL return 32'hDEADBEEF with normal latency.
REQ-032 Any out-of-range access SHALL set err_o to 1 from the next cycle until reset or clear.
REQ-033 rd_count_o and wr_count_o SHALL increment by 1 per granted read or write, including out-of-range accesses, and SHALL saturate at 16'hFFFF.

Reset
REQ-034 When rst_i=1: all pipeline valids, tcdm_r_data_o, stall_cnt, err_o and both counters SHALL be 0 after the edge.
REQ-035 While rst_i=1, tcdm_gnt_o SHALL be 0.
REQ-036 clear_i=1 SHALL behave identically to rst_i=1.
REQ-037 Memory contents SHALL NOT be reset or cleared.
REQ-038 Reads in flight at reset or clear SHALL be discarded with no response.

Verification
REQ-039 LATENCY=2, STALL_PERIOD=0: write 0x12345678 to 0x10 with be=4'hF, then read 0x10 -> gnt=1 both cycles; r_valid exactly 2 cycles after the read grant with data 0x12345678; wr_count=1, rd_count=1.
REQ-040 Write 0xAABBCCDD to 0x20 with be=4'hF, then write 0x11223344 with be=4'b0101, then read -> data 0xAA22CC44.
REQ-041 STALL_PERIOD=3, req held high for 6 cycles -> gnt pattern 1,1,0,1,1,0; 4 grants counted.
REQ-042 MEM_WORDS=1024: read address 0x1000 -> data 0xDEADBEEF; err_o=1 next cycle and stays 1; write to 0x1000 leaves memory unchanged.
REQ-043 LATENCY=4, 3 consecutive reads, rst_i asserted 2 cycles after the first grant -> no r_valid ever appears; counters 0; memory preserved on re-read.
REQ-044 Read counter: 65537 granted reads -> rd_count_o=16'hFFFF.

Source files
------------

// File: rtl/smmha_tcdm_responder.sv
// ---------------------------------------------------------------------------
// smmha_tcdm_responder
//
// Single-port TCDM slave backed by an inferred word-wide RAM. Grants are
// combinational. An optional periodic stall denies one request slot in every
// STALL_PERIOD request cycles. Reads return through a fixed LATENCY-deep
// pipeline with no back-pressure. Writes apply byte enables and produce no
// response. Accesses beyond MEM_WORDS are still granted and counted. Such
// writes are dropped, such reads return 32'hDEADBEEF, and both set a sticky
// error flag.
//
// Ports
//   clk_i          : clock, all state updates on the rising edge
//   rst_i          : synchronous active-high reset
//   clear_i        : synchronous local clear, same effect as rst_i
//   tcdm_req_i     : request valid
//   tcdm_gnt_o     : request accepted this cycle (combinational)
//   tcdm_add_i     : byte address; bits [1:0] are ignored
//   tcdm_wen_i     : 1 = read, 0 = write
//   tcdm_be_i      : write byte enables
//   tcdm_data_i    : write data
//   tcdm_r_data_o  : read data, forced to 0 when tcdm_r_valid_o is 0
//   tcdm_r_valid_o : read data valid, one pulse per granted read
//   err_o          : sticky out-of-range access flag
//   rd_count_o     : granted reads, saturating at 16'hFFFF
//   wr_count_o     : granted writes, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module smmha_tcdm_responder #(
  parameter int unsigned MEM_WORDS    = 1024,
  parameter int unsigned LATENCY      = 1,
  parameter int unsigned STALL_PERIOD = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        tcdm_req_i,
  output logic        tcdm_gnt_o,
  input  logic [31:0] tcdm_add_i,
  input  logic        tcdm_wen_i,
  input  logic [3:0]  tcdm_be_i,
  input  logic [31:0] tcdm_data_i,
  output logic [31:0] tcdm_r_data_o,
  output logic        tcdm_r_valid_o,
  output logic        err_o,
  output logic [15:0] rd_count_o,
  output logic [15:0] wr_count_o
);

  localparam int unsigned ADDR_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] OOR_DATA = 32'hDEADBEEF;

  // rst_i and clear_i have identical effect everywhere except the RAM.
  logic flush;
  assign flush = rst_i | clear_i;

  logic [29:0]       word_idx;
  logic [ADDR_W-1:0] mem_addr;
  logic              in_range;
  logic              stall;
  logic              rd_grant;
  logic              wr_grant;

  assign word_idx = tcdm_add_i[31:2];
  assign mem_addr = word_idx[ADDR_W-1:0];
  assign in_range = ({2'b00, word_idx} < 32'(MEM_WORDS));

  // Byte-offset bits carry no meaning for a word-wide array.
  logic unused_byte_offset;
  assign unused_byte_offset = ^tcdm_add_i[1:0];

  // Grant is suppressed during reset/clear so no access lands on the edge
  // that is discarding state.
  assign tcdm_gnt_o = tcdm_req_i & ~stall & ~flush;
  assign rd_grant   = tcdm_gnt_o & tcdm_wen_i;
  assign wr_grant   = tcdm_gnt_o & ~tcdm_wen_i;

  // -------------------------------------------------------------------------
  // Periodic stall: the counter advances only in request cycles. The last
  // slot of each period is denied.
  // -------------------------------------------------------------------------
  generate
    if (STALL_PERIOD == 0) begin : g_no_stall
      assign stall = 1'b0;
    end else begin : g_stall
      localparam int unsigned SC_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
      localparam logic [SC_W-1:0] SC_LAST = SC_W'(STALL_PERIOD - 1);

      logic [SC_W-1:0] stall_cnt_reg;

      assign stall = (stall_cnt_reg == SC_LAST);

      always_ff @(posedge clk_i) begin
        if (flush) begin
          stall_cnt_reg <= '0;
        end else if (tcdm_req_i) begin
          stall_cnt_reg <= (stall_cnt_reg == SC_LAST) ? '0 : stall_cnt_reg + 1'b1;
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // RAM: byte-enabled write and registered read. The read register doubles
  // as pipeline stage 0. Contents are never reset.
  // -------------------------------------------------------------------------
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] rd_word_reg;

  always_ff @(posedge clk_i) begin
    if (wr_grant && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (tcdm_be_i[b]) begin
          mem[mem_addr][8*b +: 8] <= tcdm_data_i[8*b +: 8];
        end
      end
    end
    if (rd_grant && in_range) begin
      rd_word_reg <= mem[mem_addr];
    end
  end

  // Stage 0 control: valid and out-of-range tag travel beside the RAM word.
  logic rd_valid_reg;
  logic rd_oor_reg;

  always_ff @(posedge clk_i) begin
    if (flush) begin
      rd_valid_reg <= 1'b0;
      rd_oor_reg   <= 1'b0;
    end else begin
      rd_valid_reg <= rd_grant;
      if (rd_grant) begin
        rd_oor_reg <= ~in_range;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Remaining LATENCY-1 stages. Only valids are flushed. Data is don't-care
  // whenever its valid is low because the output is gated below.
  // -------------------------------------------------------------------------
  logic        out_valid;
  logic        out_oor;
  logic [31:0] out_word;

  generate
    if (LATENCY <= 1) begin : g_lat1
      assign out_valid = rd_valid_reg;
      assign out_oor   = rd_oor_reg;
      assign out_word  = rd_word_reg;
    end else begin : g_pipe
      localparam int unsigned DEPTH = LATENCY - 1;

      logic [DEPTH-1:0] valid_pipe_reg;
      logic [DEPTH-1:0] oor_pipe_reg;
      logic [31:0]      word_pipe_reg [DEPTH];

      always_ff @(posedge clk_i) begin
        if (flush) begin
          valid_pipe_reg <= '0;
        end else begin
          valid_pipe_reg[0] <= rd_valid_reg;
          for (int k = 1; k < int'(DEPTH); k++) begin
            valid_pipe_reg[k] <= valid_pipe_reg[k-1];
          end
        end
      end

      always_ff @(posedge clk_i) begin
        oor_pipe_reg[0]  <= rd_oor_reg;
        word_pipe_reg[0] <= rd_word_reg;
        for (int k = 1; k < int'(DEPTH); k++) begin
          oor_pipe_reg[k]  <= oor_pipe_reg[k-1];
          word_pipe_reg[k] <= word_pipe_reg[k-1];
        end
      end

      assign out_valid = valid_pipe_reg[DEPTH-1];
      assign out_oor   = oor_pipe_reg[DEPTH-1];
      assign out_word  = word_pipe_reg[DEPTH-1];
    end
  endgenerate

  assign tcdm_r_valid_o = out_valid;
  assign tcdm_r_data_o  = out_valid ? (out_oor ? OOR_DATA : out_word) : 32'h0;

  // -------------------------------------------------------------------------
  // Sticky error flag and saturating access counters.
  // -------------------------------------------------------------------------
  logic        err_reg;
  logic [15:0] rd_count_reg;
  logic [15:0] wr_count_reg;

  always_ff @(posedge clk_i) begin
    if (flush) begin
      err_reg      <= 1'b0;
      rd_count_reg <= '0;
      wr_count_reg <= '0;
    end else begin
      if (tcdm_gnt_o && !in_range) begin
        err_reg <= 1'b1;
      end
      if (rd_grant && (rd_count_reg != 16'hFFFF)) begin
        rd_count_reg <= rd_count_reg + 16'd1;
      end
      if (wr_grant && (wr_count_reg != 16'hFFFF)) begin
        wr_count_reg <= wr_count_reg + 16'd1;
      end
    end
  end

  assign err_o      = err_reg;
  assign rd_count_o = rd_count_reg;
  assign wr_count_o = wr_count_reg;

endmodule

// File: tb/tb_smmha_tcdm_responder.sv
// ---------------------------------------------------------------------------
// Testbench for smmha_tcdm_responder.
// Instance A: LATENCY=2, STALL_PERIOD=0, responses checked by a scoreboard.
// Instance B: LATENCY=4, STALL_PERIOD=3, covers stall pattern and in-flight
// reset, with inline per-cycle expectations.
// ---------------------------------------------------------------------------
module tb_smmha_tcdm_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic        a_rst, a_clear, a_req, a_wen;
  logic [31:0] a_add, a_wdata;
  logic [3:0]  a_be;
  logic        a_gnt, a_rv, a_err;
  logic [31:0] a_rdata;
  logic [15:0] a_rdc, a_wrc;

  // Instance B signals
  logic        b_rst, b_clear, b_req, b_wen;
  logic [31:0] b_add, b_wdata;
  logic [3:0]  b_be;
  logic        b_gnt, b_rv, b_err;
  logic [31:0] b_rdata;
  logic [15:0] b_rdc, b_wrc;

  smmha_tcdm_responder #(.MEM_WORDS(1024), .LATENCY(2), .STALL_PERIOD(0)) u_dut_a (
    .clk_i(clk), .rst_i(a_rst), .clear_i(a_clear),
    .tcdm_req_i(a_req), .tcdm_gnt_o(a_gnt), .tcdm_add_i(a_add),
    .tcdm_wen_i(a_wen), .tcdm_be_i(a_be), .tcdm_data_i(a_wdata),
    .tcdm_r_data_o(a_rdata), .tcdm_r_valid_o(a_rv), .err_o(a_err),
    .rd_count_o(a_rdc), .wr_count_o(a_wrc)
  );

  smmha_tcdm_responder #(.MEM_WORDS(1024), .LATENCY(4), .STALL_PERIOD(3)) u_dut_b (
    .clk_i(clk), .rst_i(b_rst), .clear_i(b_clear),
    .tcdm_req_i(b_req), .tcdm_gnt_o(b_gnt), .tcdm_add_i(b_add),
    .tcdm_wen_i(b_wen), .tcdm_be_i(b_be), .tcdm_data_i(b_wdata),
    .tcdm_r_data_o(b_rdata), .tcdm_r_valid_o(b_rv), .err_o(b_err),
    .rd_count_o(b_rdc), .wr_count_o(b_wrc)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and reference model for instance A
  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] model_mem [int];
  logic [15:0] exp_rd;
  logic [15:0] exp_wr;
  logic        exp_err;
  bit          mon_en = 1'b0;

  // Response monitor for A: every valid must match the queue head on the
  // exact due cycle, idle cycles must show zero data.
  always @(negedge clk) begin
    if (mon_en) begin
      vectors++;
      if (a_rv === 1'b1) begin
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL a_unexpected_rvalid: got data %h at cycle %0d, required no response", a_rdata, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (a_rdata !== mon_e.data || cyc != mon_e.due) begin
            miscompares++;
            $display("FAIL a_read_resp: got %h at cycle %0d, required %h at cycle %0d",
                     a_rdata, cyc, mon_e.data, mon_e.due);
          end else begin
            $display("a read resp %h at cycle %0d ok", a_rdata, cyc);
          end
        end
      end else if (a_rv !== 1'b0 || a_rdata !== 32'h0) begin
        miscompares++;
        $display("FAIL a_idle_outputs: got rvalid=%b data=%h, required rvalid=0 data=0", a_rv, a_rdata);
      end else if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        miscompares++;
        mon_e = exp_q.pop_front();
        $display("FAIL a_missing_resp: got no rvalid at cycle %0d, required data %h", cyc, mon_e.data);
      end
    end
  end

  // One A cycle: drive, check grant at negedge, update model, advance.
  task automatic a_cycle(input logic req, input logic wen, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] data);
    int          idx;
    logic        oor;
    logic [31:0] old;
    a_req = req; a_wen = wen; a_add = addr; a_be = be; a_wdata = data;
    @(negedge clk);
    vectors++;
    if (a_gnt !== req) begin
      miscompares++;
      $display("FAIL a_gnt: got %b, required %b (addr %h)", a_gnt, req, addr);
    end
    if (req) begin
      idx = int'(addr[31:2]);
      oor = (addr[31:2] >= 30'd1024);
      if (oor) exp_err = 1'b1;
      if (wen) begin
        if (exp_rd != 16'hFFFF) exp_rd++;
        if (oor) exp_q.push_back('{data: 32'hDEADBEEF, due: cyc + 2});
        else     exp_q.push_back('{data: model_mem[idx], due: cyc + 2});
      end else begin
        if (exp_wr != 16'hFFFF) exp_wr++;
        if (!oor) begin
          old = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
          for (int b = 0; b < 4; b++) if (be[b]) old[8*b +: 8] = data[8*b +: 8];
          model_mem[idx] = old;
        end
      end
    end
    @(posedge clk); #1;
    a_req = 1'b0;
  endtask

  // Reset or clear A for n cycles while requesting; grant must stay low.
  task automatic a_reset(input bit use_clear, input int n);
    if (use_clear) a_clear = 1'b1; else a_rst = 1'b1;
    a_req = 1'b1; a_wen = 1'b1; a_add = 32'h0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vectors++;
      if (a_gnt !== 1'b0) begin
        miscompares++;
        $display("FAIL a_gnt_in_reset: got %b, required 0", a_gnt);
      end
      @(posedge clk); #1;
      exp_q.delete();
    end
    a_rst = 1'b0; a_clear = 1'b0; a_req = 1'b0;
    exp_rd = 16'h0; exp_wr = 16'h0; exp_err = 1'b0;
    vectors++;
    if (a_err !== 1'b0 || a_rdc !== 16'h0 || a_wrc !== 16'h0 || a_rv !== 1'b0 || a_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL a_after_reset: got err=%b rd=%h wr=%h rv=%b data=%h, required all 0",
               a_err, a_rdc, a_wrc, a_rv, a_rdata);
    end
  endtask

  // One B cycle with inline expectations on grant and response.
  task automatic b_cycle(input logic req, input logic wen, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] data, input logic rst,
                         input logic exp_gnt, input logic exp_rv, input logic [31:0] exp_rdata);
    logic [31:0] want;
    b_req = req; b_wen = wen; b_add = addr; b_be = be; b_wdata = data; b_rst = rst;
    want = exp_rv ? exp_rdata : 32'h0;
    @(negedge clk);
    vectors++;
    if (b_gnt !== exp_gnt) begin
      miscompares++;
      $display("FAIL b_gnt: got %b, required %b at cycle %0d", b_gnt, exp_gnt, cyc);
    end else begin
      $display("b cycle %0d req=%b gnt=%b ok", cyc, req, b_gnt);
    end
    vectors++;
    if (b_rv !== exp_rv || b_rdata !== want) begin
      miscompares++;
      $display("FAIL b_resp: got rvalid=%b data=%h, required rvalid=%b data=%h",
               b_rv, b_rdata, exp_rv, want);
    end
    @(posedge clk); #1;
    b_req = 1'b0; b_rst = 1'b0;
  endtask

  task automatic a_check_state(input string tag);
    vectors++;
    if (a_rdc !== exp_rd || a_wrc !== exp_wr || a_err !== exp_err) begin
      miscompares++;
      $display("FAIL a_state_%s: got rd=%h wr=%h err=%b, required rd=%h wr=%h err=%b",
               tag, a_rdc, a_wrc, a_err, exp_rd, exp_wr, exp_err);
    end else begin
      $display("a state %s rd=%h wr=%h err=%b ok", tag, a_rdc, a_wrc, a_err);
    end
  endtask

  task automatic test_reset();
    a_reset(1'b0, 2);
    for (int i = 0; i < 2; i++) b_cycle(1'b1, 1'b1, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    vectors++;
    if (b_err !== 1'b0 || b_rdc !== 16'h0 || b_wrc !== 16'h0) begin
      miscompares++;
      $display("FAIL b_after_reset: got err=%b rd=%h wr=%h, required all 0", b_err, b_rdc, b_wrc);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_write_read();
    a_cycle(1'b1, 1'b0, 32'h10, 4'hF, 32'h12345678);
    a_cycle(1'b1, 1'b1, 32'h10, 4'h0, 32'h0);
    for (int i = 0; i < 3; i++) a_cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    vectors++;
    if (a_rdc !== 16'd1 || a_wrc !== 16'd1) begin
      miscompares++;
      $display("FAIL write_read_counts: got rd=%0d wr=%0d, required rd=1 wr=1", a_rdc, a_wrc);
    end
  endtask

  task automatic test_byte_enable();
    a_cycle(1'b1, 1'b0, 32'h20, 4'hF, 32'hAABBCCDD);
    a_cycle(1'b1, 1'b0, 32'h20, 4'b0101, 32'h11223344);
    a_cycle(1'b1, 1'b1, 32'h20, 4'h0, 32'h0);
    a_cycle(1'b1, 1'b1, 32'h23, 4'h0, 32'h0);  // byte offset ignored
    for (int i = 0; i < 3; i++) a_cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    a_check_state("byte_enable");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) a_cycle(1'b1, 1'b0, 32'h100 + 32'(4*i), 4'hF, $urandom);
    for (int i = 0; i < 8; i++) a_cycle(1'b1, 1'b0, 32'h100 + 32'(4*i), 4'($urandom_range(0, 15)), $urandom);
    for (int i = 0; i < 8; i++) a_cycle(1'b1, 1'b1, 32'h100 + 32'(4*i) + 32'(i % 4), 4'h0, 32'h0);
    for (int i = 0; i < 3; i++) a_cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    a_check_state("back_to_back");
  endtask

  task automatic test_out_of_range();
    a_cycle(1'b1, 1'b0, 32'h0, 4'hF, 32'hCAFEF00D);
    a_cycle(1'b1, 1'b0, 32'hFFC, 4'hF, 32'h600DCAFE);   // last valid word
    a_cycle(1'b1, 1'b1, 32'hFFC, 4'h0, 32'h0);
    a_check_state("before_oor");
    a_cycle(1'b1, 1'b1, 32'h1000, 4'h0, 32'h0);
    a_check_state("after_oor_read");
    a_cycle(1'b1, 1'b0, 32'h1000, 4'hF, 32'h55555555);
    for (int i = 0; i < 3; i++) begin
      a_cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      a_check_state("err_sticky");
    end
    a_cycle(1'b1, 1'b1, 32'h0, 4'h0, 32'h0);
    for (int i = 0; i < 3; i++) a_cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    a_check_state("after_oor_write");
  endtask

  task automatic test_clear_in_flight();
    a_cycle(1'b1, 1'b1, 32'h0, 4'h0, 32'h0);
    a_reset(1'b1, 1);
    for (int i = 0; i < 4; i++) a_cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    a_check_state("after_clear");
    a_cycle(1'b1, 1'b1, 32'h0, 4'h0, 32'h0);
    for (int i = 0; i < 3; i++) a_cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic test_stall();
    logic [5:0] pat;
    pat = 6'b011011;  // bit i = expected grant in cycle i
    b_cycle(1'b0, 1'b1, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++)
      b_cycle(1'b1, 1'b0, 32'h40 + 32'(4*i), 4'hF, 32'h1000 + 32'(i), 1'b0, pat[i], 1'b0, 32'h0);
    vectors++;
    if (b_wrc !== 16'd4) begin
      miscompares++;
      $display("FAIL stall_grants: got wr_count=%0d, required 4", b_wrc);
    end
    // stall counter must hold across idle cycles
    b_cycle(1'b1, 1'b0, 32'h80, 4'hF, 32'h1, 1'b0, 1'b1, 1'b0, 32'h0);
    b_cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    b_cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    b_cycle(1'b1, 1'b0, 32'h84, 4'hF, 32'h2, 1'b0, 1'b1, 1'b0, 32'h0);
    b_cycle(1'b1, 1'b0, 32'h88, 4'hF, 32'h3, 1'b0, 1'b0, 1'b0, 32'h0);
    vectors++;
    if (b_wrc !== 16'd6 || b_rdc !== 16'd0) begin
      miscompares++;
      $display("FAIL stall_hold: got wr=%0d rd=%0d, required wr=6 rd=0", b_wrc, b_rdc);
    end
  endtask

  task automatic test_reset_in_flight();
    b_cycle(1'b0, 1'b1, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    b_cycle(1'b1, 1'b0, 32'h8, 4'hF, 32'h0BADF00D, 1'b0, 1'b1, 1'b0, 32'h0);
    b_cycle(1'b0, 1'b1, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    b_cycle(1'b1, 1'b1, 32'h8, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    b_cycle(1'b1, 1'b1, 32'h8, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    b_cycle(1'b1, 1'b1, 32'h8, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) b_cycle(1'b0, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    vectors++;
    if (b_rdc !== 16'd0 || b_wrc !== 16'd0 || b_err !== 1'b0) begin
      miscompares++;
      $display("FAIL b_inflight_counts: got rd=%0d wr=%0d err=%b, required 0 0 0", b_rdc, b_wrc, b_err);
    end
    b_cycle(1'b1, 1'b1, 32'h8, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    b_cycle(1'b0, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    b_cycle(1'b0, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    b_cycle(1'b0, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    b_cycle(1'b0, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0BADF00D);
    b_cycle(1'b0, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_saturation();
    a_reset(1'b0, 1);
    for (int i = 0; i < 65537; i++) begin
      a_cycle(1'b1, 1'b1, 32'h10, 4'h0, 32'h0);
      if (i == 65533) begin
        vectors++;
        if (a_rdc !== 16'hFFFE) begin
          miscompares++;
          $display("FAIL rd_count_near_sat: got %h, required FFFE", a_rdc);
        end
      end
    end
    for (int i = 0; i < 3; i++) a_cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    vectors++;
    if (a_rdc !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL rd_count_sat: got %h, required FFFF", a_rdc);
    end else begin
      $display("rd_count saturated at %h ok", a_rdc);
    end
  endtask

  initial begin
    a_rst = 1'b0; a_clear = 1'b0; a_req = 1'b0; a_wen = 1'b0;
    a_add = 32'h0; a_wdata = 32'h0; a_be = 4'h0;
    b_rst = 1'b0; b_clear = 1'b0; b_req = 1'b0; b_wen = 1'b0;
    b_add = 32'h0; b_wdata = 32'h0; b_be = 4'h0;
    exp_rd = 16'h0; exp_wr = 16'h0; exp_err = 1'b0;
    @(posedge clk); #1;

    test_reset();
    test_write_read();
    test_byte_enable();
    test_back_to_back();
    test_out_of_range();
    test_clear_in_flight();
    test_stall();
    test_reset_in_flight();
    test_saturation();

    for (int i = 0; i < 4; i++) a_cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_responses: got %0d outstanding, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
